// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - data-memory req/ack bus between the M-stage controller and memory
interface dmem_access_ctrl_if #(
  parameter int XLEN = 32
);
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [3:0]      dmem_wstrb_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic            dmem_ack_i;
  logic [XLEN-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - M-stage load/store sequencer with stall, alignment and timeout
module dmem_access_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst,
  input  logic               ED_mem_rd_i,
  input  logic               ED_mem_wr_i,
  input  logic [2:0]         ED_funct3_i,
  input  logic [XLEN-1:0]    ED_valE_i,
  input  logic [XLEN-1:0]    ED_wdata_i,
  dmem_access_ctrl_if.master dmem,
  output logic [XLEN-1:0]    M_valM_o,
  output logic               M_bubble_o,
  output logic               upstream_stall_o,
  output logic               misalign_o,
  output logic               timeout_err_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  // The IDLE request cycle is the first wait cycle, so WAIT gives up one count earlier.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;

  logic            w_memop;
  logic            w_is_byte;
  logic            w_is_half;
  logic            w_is_word;
  logic            w_signed;
  logic [1:0]      w_off;
  logic            w_misalign;
  logic            w_req;
  logic            w_ack;
  logic            w_last;
  logic            w_stall;
  logic [7:0]      w_rbyte;
  logic [15:0]     w_rhalf;
  logic [XLEN-1:0] w_load;

  assign w_memop    = ED_mem_rd_i | ED_mem_wr_i;
  assign w_is_byte  = (ED_funct3_i[1:0] == 2'b00);
  assign w_is_half  = (ED_funct3_i[1:0] == 2'b01);
  assign w_is_word  = ED_funct3_i[1];
  assign w_signed   = ~ED_funct3_i[2];
  assign w_off      = ED_valE_i[1:0];
  assign w_misalign = w_memop & ((w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00)));

  // Requests are suppressed while reset is held so an abandoned access never reissues.
  assign w_req   = ~rst & ((r_state == WAIT) | (w_memop & ~w_misalign));
  assign w_ack   = w_req & dmem.dmem_ack_i;
  assign w_last  = (r_state == WAIT) & ~dmem.dmem_ack_i & (r_cnt == LAST_CNT);
  assign w_stall = w_req & ~dmem.dmem_ack_i & ~w_last;

  assign dmem.dmem_req_o   = w_req;
  assign dmem.dmem_we_o    = w_req & ED_mem_wr_i;
  assign dmem.dmem_addr_o  = {ED_valE_i[XLEN-1:2], 2'b00};
  assign dmem.dmem_wstrb_o = !(w_req & ED_mem_wr_i) ? 4'b0000 :
                             w_is_byte ? (4'b0001 << w_off) :
                             w_is_half ? (4'b0011 << w_off) : 4'b1111;
  assign dmem.dmem_wdata_o = w_is_byte ? {4{ED_wdata_i[7:0]}} :
                             w_is_half ? {2{ED_wdata_i[15:0]}} : ED_wdata_i;

  assign w_rbyte = dmem.dmem_rdata_i[{w_off, 3'b000} +: 8];
  assign w_rhalf = w_off[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
  assign w_load  = w_is_byte ? {{(XLEN-8){w_signed & w_rbyte[7]}}, w_rbyte} :
                   w_is_half ? {{(XLEN-16){w_signed & w_rhalf[15]}}, w_rhalf} :
                   dmem.dmem_rdata_i;

  assign M_valM_o         = (ED_mem_rd_i & w_ack) ? w_load : '0;
  assign upstream_stall_o = w_stall;
  assign M_bubble_o       = w_stall;
  assign misalign_o       = ~rst & (r_state == IDLE) & w_misalign;
  assign timeout_err_o    = r_timeout_err;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_stall) r_state <= WAIT;
        end
        WAIT: begin
          if (w_ack || w_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_last) r_timeout_err <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed vector bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        ED_mem_rd_i, ED_mem_wr_i;
  logic [2:0]  ED_funct3_i;
  logic [31:0] ED_valE_i, ED_wdata_i;
  logic [31:0] M_valM_o;
  logic        M_bubble_o, upstream_stall_o, misalign_o, timeout_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_access_ctrl_if #(.XLEN(32)) dmem_bus ();

  dmem_access_ctrl #(.XLEN(32), .TIMEOUT(4), .CNT_W(3)) dut (
    .clk_i            (clk_i),
    .rst              (rst),
    .ED_mem_rd_i      (ED_mem_rd_i),
    .ED_mem_wr_i      (ED_mem_wr_i),
    .ED_funct3_i      (ED_funct3_i),
    .ED_valE_i        (ED_valE_i),
    .ED_wdata_i       (ED_wdata_i),
    .dmem             (dmem_bus),
    .M_valM_o         (M_valM_o),
    .M_bubble_o       (M_bubble_o),
    .upstream_stall_o (upstream_stall_o),
    .misalign_o       (misalign_o),
    .timeout_err_o    (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_valm;
    logic        e_stall, e_mis;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ack, input logic [31:0] rdata);
    ED_mem_rd_i           = rd;
    ED_mem_wr_i           = wr;
    ED_funct3_i           = f3;
    ED_valE_i             = addr;
    ED_wdata_i            = wdata;
    dmem_bus.dmem_ack_i   = ack;
    dmem_bus.dmem_rdata_i = rdata;
  endtask

  task automatic chk_hs(input string tag, input logic req, input logic stall, input logic [31:0] valm);
    chk({tag, " req"}, {31'd0, dmem_bus.dmem_req_o}, {31'd0, req});
    chk({tag, " stall"}, {31'd0, upstream_stall_o}, {31'd0, stall});
    chk({tag, " bubble"}, {31'd0, M_bubble_o}, {31'd0, stall});
    chk({tag, " valM"}, M_valM_o, valm);
  endtask

  initial begin
    //            rd wr f3      addr          wdata         ack rdata         req we e_addr        strb     e_wdata       e_valm        st mis
    vt[0]  = '{1'b0,1'b0,3'b010,32'h0000_0100,32'h0,        1'b1,32'h1234_5678,1'b0,1'b0,32'h0000_0100,4'b0000,32'h0,        32'h0,        1'b0,1'b0};
    vt[1]  = '{1'b1,1'b0,3'b010,32'h0000_0100,32'h0,        1'b1,32'hDEAD_BEEF,1'b1,1'b0,32'h0000_0100,4'b0000,32'h0,        32'hDEAD_BEEF,1'b0,1'b0};
    vt[2]  = '{1'b0,1'b1,3'b001,32'h0000_0022,32'h0000_ABCD,1'b1,32'h0,        1'b1,1'b1,32'h0000_0020,4'b1100,32'hABCD_ABCD,32'h0,        1'b0,1'b0};
    vt[3]  = '{1'b0,1'b1,3'b000,32'h0000_0021,32'h0000_00A5,1'b1,32'h0,        1'b1,1'b1,32'h0000_0020,4'b0010,32'hA5A5_A5A5,32'h0,        1'b0,1'b0};
    vt[4]  = '{1'b0,1'b1,3'b010,32'h0000_0044,32'h1122_3344,1'b1,32'h0,        1'b1,1'b1,32'h0000_0044,4'b1111,32'h1122_3344,32'h0,        1'b0,1'b0};
    vt[5]  = '{1'b1,1'b0,3'b001,32'h0000_0006,32'h0,        1'b1,32'h8001_7FFF,1'b1,1'b0,32'h0000_0004,4'b0000,32'h0,        32'hFFFF_8001,1'b0,1'b0};
    vt[6]  = '{1'b1,1'b0,3'b101,32'h0000_0006,32'h0,        1'b1,32'h8001_7FFF,1'b1,1'b0,32'h0000_0004,4'b0000,32'h0,        32'h0000_8001,1'b0,1'b0};
    vt[7]  = '{1'b1,1'b0,3'b001,32'h0000_0004,32'h0,        1'b1,32'h8001_7FFF,1'b1,1'b0,32'h0000_0004,4'b0000,32'h0,        32'h0000_7FFF,1'b0,1'b0};
    vt[8]  = '{1'b1,1'b0,3'b000,32'h0000_0101,32'h0,        1'b1,32'h80FF_1234,1'b1,1'b0,32'h0000_0100,4'b0000,32'h0,        32'h0000_0012,1'b0,1'b0};
    vt[9]  = '{1'b1,1'b0,3'b000,32'h0000_0102,32'h0,        1'b1,32'h80FF_1234,1'b1,1'b0,32'h0000_0100,4'b0000,32'h0,        32'hFFFF_FFFF,1'b0,1'b0};
    vt[10] = '{1'b1,1'b0,3'b100,32'h0000_0102,32'h0,        1'b1,32'h80FF_1234,1'b1,1'b0,32'h0000_0100,4'b0000,32'h0,        32'h0000_00FF,1'b0,1'b0};
    vt[11] = '{1'b1,1'b0,3'b010,32'h0000_0102,32'h0,        1'b1,32'hDEAD_BEEF,1'b0,1'b0,32'h0000_0100,4'b0000,32'h0,        32'h0,        1'b0,1'b1};
    vt[12] = '{1'b0,1'b1,3'b001,32'h0000_0023,32'h0000_BEEF,1'b1,32'h0,        1'b0,1'b0,32'h0000_0020,4'b0000,32'hBEEF_BEEF,32'h0,        1'b0,1'b1};
    vt[13] = '{1'b1,1'b0,3'b101,32'h0000_0001,32'h0,        1'b1,32'hFFFF_FFFF,1'b0,1'b0,32'h0000_0000,4'b0000,32'h0,        32'h0,        1'b0,1'b1};
    vt[14] = '{1'b0,1'b1,3'b010,32'h0000_0042,32'h1122_3344,1'b1,32'h0,        1'b0,1'b0,32'h0000_0040,4'b0000,32'h1122_3344,32'h0,        1'b0,1'b1};
    vt[15] = '{1'b0,1'b1,3'b000,32'h0000_0023,32'h0000_005A,1'b1,32'h0,        1'b1,1'b1,32'h0000_0020,4'b1000,32'h5A5A_5A5A,32'h0,        1'b0,1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk_i);
    chk("reset req", {31'd0, dmem_bus.dmem_req_o}, 32'd0);
    chk("reset stall", {31'd0, upstream_stall_o}, 32'd0);
    chk("reset terr", {31'd0, timeout_err_o}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      drive(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].ack, vt[i].rdata);
      #1;
      chk($sformatf("v%0d req", i), {31'd0, dmem_bus.dmem_req_o}, {31'd0, vt[i].e_req});
      chk($sformatf("v%0d we", i), {31'd0, dmem_bus.dmem_we_o}, {31'd0, vt[i].e_we});
      chk($sformatf("v%0d addr", i), dmem_bus.dmem_addr_o, vt[i].e_addr);
      chk($sformatf("v%0d wstrb", i), {28'd0, dmem_bus.dmem_wstrb_o}, {28'd0, vt[i].e_strb});
      chk($sformatf("v%0d wdata", i), dmem_bus.dmem_wdata_o, vt[i].e_wdata);
      chk($sformatf("v%0d valM", i), M_valM_o, vt[i].e_valm);
      chk($sformatf("v%0d stall", i), {31'd0, upstream_stall_o}, {31'd0, vt[i].e_stall});
      chk($sformatf("v%0d bubble", i), {31'd0, M_bubble_o}, {31'd0, vt[i].e_stall});
      chk($sformatf("v%0d misalign", i), {31'd0, misalign_o}, {31'd0, vt[i].e_mis});
    end

    // Three-cycle LB at 0x103, then back-to-back LBU with no idle cycle.
    @(negedge clk_i); drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'h80FF_1234); #1;
    chk_hs("lb3 c1", 1'b1, 1'b1, 32'h0);
    @(negedge clk_i); #1;
    chk_hs("lb3 c2", 1'b1, 1'b1, 32'h0);
    @(negedge clk_i); dmem_bus.dmem_ack_i = 1'b1; #1;
    chk_hs("lb3 c3", 1'b1, 1'b0, 32'hFFFF_FF80);
    @(negedge clk_i); drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 32'h80FF_1234); #1;
    chk_hs("lbu b2b", 1'b1, 1'b0, 32'h0000_0080);

    // Timeout with TIMEOUT = 4: three stall cycles, fourth abandons.
    @(negedge clk_i); drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'h5555_5555); #1;
    chk_hs("to c1", 1'b1, 1'b1, 32'h0);
    @(negedge clk_i); #1;
    chk_hs("to c2", 1'b1, 1'b1, 32'h0);
    @(negedge clk_i); #1;
    chk_hs("to c3", 1'b1, 1'b1, 32'h0);
    @(negedge clk_i); #1;
    chk_hs("to c4", 1'b1, 1'b0, 32'h0);
    chk("to c4 terr", {31'd0, timeout_err_o}, 32'd0);
    @(negedge clk_i); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0); #1;
    chk_hs("to idle", 1'b0, 1'b0, 32'h0);
    chk("to terr set", {31'd0, timeout_err_o}, 32'd1);
    @(negedge clk_i); drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 32'hCAFE_F00D); #1;
    chk_hs("to after", 1'b1, 1'b0, 32'hCAFE_F00D);
    repeat (3) @(negedge clk_i);
    chk("to terr sticky", {31'd0, timeout_err_o}, 32'd1);

    // Reset asserted mid-WAIT takes effect without a clock edge.
    @(negedge clk_i); drive(1'b0, 1'b1, 3'b010, 32'h400, 32'h1234_5678, 1'b0, 32'h0); #1;
    chk_hs("rw c1", 1'b1, 1'b1, 32'h0);
    @(negedge clk_i); #1;
    chk_hs("rw wait", 1'b1, 1'b1, 32'h0);
    #1 rst = 1'b1; #1;
    chk_hs("rw async", 1'b0, 1'b0, 32'h0);
    chk("rw terr", {31'd0, timeout_err_o}, 32'd0);
    @(negedge clk_i); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    @(negedge clk_i); #1;
    chk_hs("rw idle", 1'b0, 1'b0, 32'h0);
    @(negedge clk_i); drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 1'b1, 32'h0BAD_F00D); #1;
    chk_hs("rw resume", 1'b1, 1'b0, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
